axil_kg_reg_file: RTL and testbench



---
 rtl/axil_kg_reg_file.sv | 190 +++++++++++++++++++
 tb/tb_axil_kg_reg_file.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_kg_reg_file.sv
// AXI4-Lite register file holding the Kugelblitz offload configuration (address, data, valid flags).
// Optional SCRATCH register at 0x10 enabled by defining KG_REGFILE_SCRATCH_EN.
module axil_kg_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [DATA_WIDTH-1:0] kg_address,
  output logic [DATA_WIDTH-1:0] kg_address_valid,
  output logic [DATA_WIDTH-1:0] kg_data,
  output logic [DATA_WIDTH-1:0] kg_data_valid
);

  localparam logic [DATA_WIDTH-1:0] ID_VALUE = 32'h4B47_0001;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axil_kg_reg_file: DATA_WIDTH must be 32");
  end
  if (STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_strb_width
    $error("axil_kg_reg_file: STRB_WIDTH must equal DATA_WIDTH/8");
  end
  if (ADDR_WIDTH < 5) begin : g_bad_addr_width
    $error("axil_kg_reg_file: ADDR_WIDTH must be at least 5");
  end

  function automatic logic [DATA_WIDTH-1:0] apply_strb(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] kg_address_q, kg_address_d;
  logic [DATA_WIDTH-1:0] kg_address_valid_q, kg_address_valid_d;
  logic [DATA_WIDTH-1:0] kg_data_q, kg_data_d;
  logic [DATA_WIDTH-1:0] kg_data_valid_q, kg_data_valid_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic                  awready_q, awready_d;
  logic                  bvalid_q, bvalid_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [2:0]            wr_idx;
  logic [2:0]            rd_idx;
  logic                  wr_en;
  logic                  rd_en;
  logic                  unused_ok;

  // Protection bits and address bits outside [4:2] carry no meaning here.
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  // Next-state logic for both channels and the register contents.
  always_comb begin
    wr_idx = s_axil_awaddr[4:2];
    rd_idx = s_axil_araddr[4:2];
    // A transfer completes on the edge where the one-cycle ready pulse meets valid.
    wr_en  = awready_q && s_axil_awvalid && s_axil_wvalid;
    rd_en  = arready_q && s_axil_arvalid;

    awready_d = s_axil_awvalid && s_axil_wvalid && !bvalid_q && !awready_q;
    arready_d = s_axil_arvalid && !rvalid_q && !arready_q;

    if (wr_en) begin
      bvalid_d = 1'b1;
    end else if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    kg_address_d       = kg_address_q;
    kg_address_valid_d = kg_address_valid_q;
    kg_data_d          = kg_data_q;
    kg_data_valid_d    = kg_data_valid_q;
    scratch_d          = scratch_q;
    if (wr_en) begin
      case (wr_idx)
        3'd0: kg_address_d       = apply_strb(kg_address_q, s_axil_wdata, s_axil_wstrb);
        3'd1: kg_address_valid_d = apply_strb(kg_address_valid_q, s_axil_wdata, s_axil_wstrb);
        3'd2: kg_data_d          = apply_strb(kg_data_q, s_axil_wdata, s_axil_wstrb);
        3'd3: kg_data_valid_d    = apply_strb(kg_data_valid_q, s_axil_wdata, s_axil_wstrb);
`ifdef KG_REGFILE_SCRATCH_EN
        3'd4: scratch_d          = apply_strb(scratch_q, s_axil_wdata, s_axil_wstrb);
`endif
        default: begin
        end
      endcase
    end else begin
      scratch_d = scratch_q;
    end

    case (rd_idx)
      3'd0: rd_mux = kg_address_q;
      3'd1: rd_mux = kg_address_valid_q;
      3'd2: rd_mux = kg_data_q;
      3'd3: rd_mux = kg_data_valid_q;
`ifdef KG_REGFILE_SCRATCH_EN
      3'd4: rd_mux = scratch_q;
`else
      3'd4: rd_mux = {DATA_WIDTH{1'b0}};
`endif
      3'd7: rd_mux = ID_VALUE;
      default: rd_mux = {DATA_WIDTH{1'b0}};
    endcase

    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
    end else begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      kg_address_q       <= {DATA_WIDTH{1'b0}};
      kg_address_valid_q <= {DATA_WIDTH{1'b0}};
      kg_data_q          <= {DATA_WIDTH{1'b0}};
      kg_data_valid_q    <= {DATA_WIDTH{1'b0}};
      scratch_q          <= {DATA_WIDTH{1'b0}};
      awready_q          <= 1'b0;
      bvalid_q           <= 1'b0;
      arready_q          <= 1'b0;
      rvalid_q           <= 1'b0;
      rdata_q            <= {DATA_WIDTH{1'b0}};
    end else begin
      kg_address_q       <= kg_address_d;
      kg_address_valid_q <= kg_address_valid_d;
      kg_data_q          <= kg_data_d;
      kg_data_valid_q    <= kg_data_valid_d;
      scratch_q          <= scratch_d;
      awready_q          <= awready_d;
      bvalid_q           <= bvalid_d;
      arready_q          <= arready_d;
      rvalid_q           <= rvalid_d;
      rdata_q            <= rdata_d;
    end
  end

  assign s_axil_awready   = awready_q;
  assign s_axil_wready    = awready_q;
  assign s_axil_bresp     = 2'b00;
  assign s_axil_bvalid    = bvalid_q;
  assign s_axil_arready   = arready_q;
  assign s_axil_rdata     = rdata_q;
  assign s_axil_rresp     = 2'b00;
  assign s_axil_rvalid    = rvalid_q;
  assign kg_address       = kg_address_q;
  assign kg_address_valid = kg_address_valid_q;
  assign kg_data          = kg_data_q;
  assign kg_data_valid    = kg_data_valid_q;

endmodule

// File: tb/tb_axil_kg_reg_file.sv
// Directed bench for axil_kg_reg_file: register-map model plus per-cycle output comparison.
module tb_axil_kg_reg_file;

  localparam logic [31:0] ID_VALUE = 32'h4B47_0001;
`ifdef KG_REGFILE_SCRATCH_EN
  localparam bit          SCR_EN  = 1'b1;
  localparam logic [31:0] SCR_EXP = 32'h0022_0044;
`else
  localparam bit          SCR_EN  = 1'b0;
  localparam logic [31:0] SCR_EXP = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] kg_address, kg_address_valid, kg_data, kg_data_valid;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;
  logic [31:0] m_regs [0:7];

  always #5 clk = ~clk;

  axil_kg_reg_file dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .kg_address(kg_address), .kg_address_valid(kg_address_valid),
    .kg_data(kg_data), .kg_data_valid(kg_data_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register map model: word index selects slot, only RW slots take writes.
  function automatic bit m_writable(input logic [31:0] addr);
    int idx = int'((addr >> 2) & 32'd7);
    return (idx <= 3) || (idx == 4 && SCR_EN);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int idx = int'((addr >> 2) & 32'd7);
    if (idx == 7) return ID_VALUE;
    if (m_writable(addr)) return m_regs[idx];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = int'((addr >> 2) & 32'd7);
    if (m_writable(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
  endtask

  // Every cycle, outputs must equal the model's register contents.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("kg_address", kg_address, m_regs[0]);
      check("kg_address_valid", kg_address_valid, m_regs[1]);
      check("kg_data", kg_data, m_regs[2]);
      check("kg_data_valid", kg_data_valid, m_regs[3]);
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, input int b_delay, input bit nxt_en,
                           input logic [31:0] nxt_addr, input logic [31:0] nxt_data);
    bit seen = 1'b0;
    awaddr  = addr;
    awvalid = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      @(negedge clk);
      check("aw_without_w_ready", {31'b0, awready}, 32'h0);
    end
    wdata  = data;
    wstrb  = strb;
    wvalid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = awready;
    end
    check("awready_seen", {31'b0, awready}, 32'h1);
    check("wready_with_awready", {31'b0, wready}, 32'h1);
    @(posedge clk);
    model_write(addr, data, strb);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(negedge clk);
    check("bvalid_after_hs", {31'b0, bvalid}, 32'h1);
    check("bresp", {30'b0, bresp}, 32'h0);
    check("awready_single_pulse", {31'b0, awready}, 32'h0);
    if (nxt_en) begin
      awaddr = nxt_addr; wdata = nxt_data; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
    end
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      check("bvalid_hold", {31'b0, bvalid}, 32'h1);
      check("awready_blocked", {31'b0, awready}, 32'h0);
    end
    bready = 1'b1;
    @(posedge clk);
    #1 bready = 1'b0;
    @(negedge clk);
    check("bvalid_cleared", {31'b0, bvalid}, 32'h0);
    check("awready_after_b", {31'b0, awready}, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    axi_write(addr, data, strb, 0, 0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input int r_delay);
    bit seen = 1'b0;
    araddr  = addr;
    arvalid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = arready;
    end
    check("arready_seen", {31'b0, arready}, 32'h1);
    @(posedge clk);
    #1 arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_after_hs", {31'b0, rvalid}, 32'h1);
    check($sformatf("rdata_%h", addr), rdata, exp);
    check("rresp", {30'b0, rresp}, 32'h0);
    for (int i = 0; i < r_delay; i++) begin
      @(negedge clk);
      check("rvalid_hold", {31'b0, rvalid}, 32'h1);
      check("rdata_hold", rdata, exp);
      check("arready_blocked", {31'b0, arready}, 32'h0);
    end
    rready = 1'b1;
    @(posedge clk);
    #1 rready = 1'b0;
    @(negedge clk);
    check("rvalid_cleared", {31'b0, rvalid}, 32'h0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'b0, awready}, 32'h0);
    check("rst_wready", {31'b0, wready}, 32'h0);
    check("rst_bvalid", {31'b0, bvalid}, 32'h0);
    check("rst_arready", {31'b0, arready}, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    axi_read(32'h00, 32'h0, 0);
    axi_read(32'h04, 32'h0, 0);
    axi_read(32'h08, 32'h0, 0);
    axi_read(32'h0C, 32'h0, 0);
    axi_read(32'h1C, 32'h4B47_0001, 0);

    wr(32'h08, 32'h0000_00A5, 4'hF);
    check("lit_kg_data_a5", kg_data, 32'h0000_00A5);
    axi_read(32'h08, 32'h0000_00A5, 0);

    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h00, 32'h1234_5678, 4'h3);
    check("lit_kg_address_partial", kg_address, 32'hFFFF_5678);
    axi_read(32'h00, model_read(32'h00), 0);

    axi_write(32'h04, 32'h1, 4'hF, 0, 5, 1'b1, 32'h0C, 32'h1);
    axi_write(32'h0C, 32'h1, 4'hF, 0, 0, 1'b0, 32'h0, 32'h0);
    check("lit_kg_address_valid", kg_address_valid, 32'h1);
    check("lit_kg_data_valid", kg_data_valid, 32'h1);

    axi_write(32'h0C, 32'h0000_0080, 4'h1, 3, 0, 1'b0, 32'h0, 32'h0);
    check("lit_kg_data_valid_b0", kg_data_valid, 32'h0000_0080);
    axi_read(32'h08, 32'h0000_00A5, 4);

    wr(32'h14, 32'h0000_DEAD, 4'hF);
    wr(32'h1C, 32'h0, 4'hF);
    axi_read(32'h14, 32'h0, 0);
    axi_read(32'h1C, 32'h4B47_0001, 0);
    wr(32'h10, 32'h1122_3344, 4'h5);
    axi_read(32'h10, SCR_EXP, 0);
    axi_read(32'h18, model_read(32'h18), 0);

    wr(32'h23, 32'hCAFE_BABE, 4'hF);
    axi_read(32'h28, 32'h0000_00A5, 0);
    axi_read(32'h00, 32'hCAFE_BABE, 0);

    // Read and write to the same register on the same edge: read sees the old value.
    fork
      wr(32'h08, 32'h5A5A_5A5A, 4'hF);
      axi_read(32'h08, 32'h0000_00A5, 0);
    join
    axi_read(32'h08, 32'h5A5A_5A5A, 0);

    // Reset while both a read and a write response are pending.
    araddr = 32'h04; arvalid = 1'b1;
    awaddr = 32'h0C; wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("mid_arready", {31'b0, arready}, 32'h1);
    check("mid_awready", {31'b0, awready}, 32'h1);
    @(posedge clk);
    model_write(32'h0C, 32'h0000_0077, 4'hF);
    #1 arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("mid_rvalid", {31'b0, rvalid}, 32'h1);
    check("mid_bvalid", {31'b0, bvalid}, 32'h1);
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    check("rst_drop_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_drop_bvalid", {31'b0, bvalid}, 32'h0);
    check("rst_kg_data", kg_data, 32'h0);
    check("rst_kg_data_valid", kg_data_valid, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_stale_rvalid", {31'b0, rvalid}, 32'h0);
    check("no_stale_bvalid", {31'b0, bvalid}, 32'h0);
    axi_read(32'h00, 32'h0, 0);
    axi_read(32'h1C, 32'h4B47_0001, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
